seq_encoder8_3: RTL and testbench
=================================

// Module: seq_encoder8_3
// PURPOSE
//  Sequential 8-to-3 encoder: the inverse of the 3-to-8 decoder. Accepts an
//  8-bit request vector via valid/ready and emits one 3-bit code per set bit,
//  in priority order, over successive output handshakes. Sits between request
//  sources, such as decoder outputs or interrupt lines, and any consumer of
//  binary codes.
// PARAMETERS
//  HIGH_FIRST  1  1: highest set index emitted first (Y7..Y0); 0: lowest first
//  ZERO_BEAT   1  1: all-zero vector yields one beat with out_zero=1; 0: dropped
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  synchronous active-low reset
//  en         in   1  block enable; low freezes the block (see BEHAVIOUR)
//  in_valid   in   1  in_vec is valid
//  in_ready   out  1  block can accept a vector this cycle
//  in_vec     in   8  request vector; bit i corresponds to code i
//  out_valid  out  1  out_code/out_last/out_zero are valid
//  out_ready  in   1  consumer accepts the current beat
//  out_code   out  3  binary index of the current set bit
//  out_last   out  1  current beat is the final beat for this vector
//  out_zero   out  1  beat reports an all-zero vector (out_code=0)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, pend=0. While rst_n=0: in_ready=0,
//  out_valid=0, out_code=0, out_last=0, out_zero=0. Reset mid-burst abandons
//  the remaining bits with no further beats.
//  State IDLE:
//    in_ready = en; out_valid=0.
//    Accept when in_valid&in_ready: pend<=in_vec, go to EMIT.
//    in_vec=0 with ZERO_BEAT=1: go to EMIT with zero flag set.
//    in_vec=0 with ZERO_BEAT=0: stay IDLE; the vector is consumed silently.
//  State EMIT:
//    in_ready=0; out_valid=en.
//    out_code = priority index of pend (highest or lowest per HIGH_FIRST).
//    out_last = (popcount(pend)==1) | zero flag.
//    Outputs are registered or derived from registered pend only; they do not
//    depend combinationally on in_*.
//  Latency: first out_valid is the cycle after acceptance. With out_ready held
//    high, beats are back-to-back, one per cycle.
//  Beat transfer (out_valid&out_ready):
//    Clear the emitted bit of pend.
//    If out_last: go to IDLE. in_ready rises the next cycle, so there is no
//    same-cycle re-accept; minimum gap between vectors is 1 cycle.
//  Backpressure: while out_valid&!out_ready, out_code/out_last/out_zero are
//    held stable.
//  en=0 in EMIT: out_valid=0 and state/pend are frozen. The burst resumes with
//    the same code when en returns.
//  en=0 in IDLE: in_ready=0.
//  Simultaneous en fall and out_ready high: no transfer, because out_valid=0.
// TESTING
//  1. en=1, in_vec=8'h01 accepted -> next cycle one beat: code=0, last=1,
//     zero=0; in_ready=1 the cycle after.
//  2. HIGH_FIRST=1, in_vec=8'hA5, out_ready=1 -> codes 7,5,2,0 on 4
//     consecutive cycles; last only on code 0; in_ready=0 throughout.
//  3. HIGH_FIRST=0, in_vec=8'hA5 -> codes 0,2,5,7. Then in_vec=8'h80 -> a
//     single beat, code=7, last=1.
//  4. in_vec=8'hC0, out_ready=0 for 3 cycles -> code=7 held stable with
//     out_valid=1. Raise out_ready -> codes 7 then 6.
//  5. in_vec=8'h00, ZERO_BEAT=1 -> one beat: code=0, zero=1, last=1.
//     ZERO_BEAT=0 -> no beat; in_ready stays 1.
//  6. in_vec=8'hFF. en=0 after 2 beats -> out_valid=0; en=1 -> resumes at
//     code 5. rst_n=0 mid-burst -> all outputs 0; after release in_ready=1
//     and no stale beats appear.

Source files
------------

// File: rtl/seq_encoder8_3.sv
// seq_encoder8_3 -- sequential 8-to-3 encoder.
// Accepts an 8-bit request vector over a valid/ready handshake and emits one
// 3-bit code per set bit, in priority order, one beat per output handshake.
//
// Parameters
//   HIGH_FIRST  1: highest set index first; 0: lowest set index first
//   ZERO_BEAT   1: all-zero vector yields one beat with out_zero=1; 0: dropped
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         block enable; low freezes state and hides out_valid/in_ready
//   in_valid   in_vec is valid
//   in_ready   block can accept a vector this cycle
//   in_vec     request vector; bit i maps to code i
//   out_valid  out_code/out_last/out_zero are valid
//   out_ready  consumer accepts the current beat
//   out_code   binary index of the current set bit
//   out_last   final beat for this vector
//   out_zero   beat reports an all-zero vector (out_code=0)
module seq_encoder8_3 #(
  parameter bit HIGH_FIRST = 1'b1,
  parameter bit ZERO_BEAT  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic       out_zero
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state;
  logic [7:0] pend;     // bits still to be emitted
  logic       zero_q;   // current burst is the single all-zero beat

  logic [2:0] prio;
  logic       single;
  logic       emit;

  // Priority pick over pend. The loop's last match wins, so scanning upward
  // selects the highest set bit and scanning downward selects the lowest.
  always_comb begin
    prio = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++)
        if (pend[i]) prio = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (pend[i]) prio = 3'(i);
    end
  end

  // Exactly one bit left: pend nonzero and clearing its lowest bit empties it.
  assign single = (pend != 8'd0) && ((pend & (pend - 8'd1)) == 8'd0);

  // Outputs depend only on registered state; rst_n gating keeps them at zero
  // for the whole time reset is asserted, not just after the first edge.
  assign emit      = rst_n && (state == EMIT);
  assign in_ready  = rst_n && en && (state == IDLE);
  assign out_valid = emit && en;
  assign out_code  = emit ? prio : 3'd0;
  assign out_last  = emit && (single || zero_q);
  assign out_zero  = emit && zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend   <= 8'd0;
      zero_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            pend   <= in_vec;
            zero_q <= (in_vec == 8'd0);
            // A zero vector without ZERO_BEAT is consumed with no beat.
            if ((in_vec != 8'd0) || ZERO_BEAT) state <= EMIT;
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            pend <= pend & ~(8'd1 << prio);
            if (out_last) begin
              state  <= IDLE;
              zero_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_encoder8_3.sv
// Bench for seq_encoder8_3. Two instances share stimulus:
//   u_hz: HIGH_FIRST=1, ZERO_BEAT=1
//   u_lz: HIGH_FIRST=0, ZERO_BEAT=0
// Expected beats are queued when a vector is driven and popped as beats
// transfer.
module tb_seq_encoder8_3;

  logic       clk = 1'b0;
  logic       rst_n, en, in_valid, out_ready;
  logic [7:0] in_vec;

  logic       hz_ready, hz_valid, hz_last, hz_zero;
  logic [2:0] hz_code;
  logic       lz_ready, lz_valid, lz_last, lz_zero;
  logic [2:0] lz_code;

  always #5 clk = ~clk;

  seq_encoder8_3 #(.HIGH_FIRST(1'b1), .ZERO_BEAT(1'b1)) u_hz (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(hz_ready),
    .in_vec(in_vec), .out_valid(hz_valid), .out_ready(out_ready),
    .out_code(hz_code), .out_last(hz_last), .out_zero(hz_zero));

  seq_encoder8_3 #(.HIGH_FIRST(1'b0), .ZERO_BEAT(1'b0)) u_lz (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(lz_ready),
    .in_vec(in_vec), .out_valid(lz_valid), .out_ready(out_ready),
    .out_code(lz_code), .out_last(lz_last), .out_zero(lz_zero));

  typedef struct {
    logic [2:0] code;
    logic       last;
    logic       zero;
  } beat_t;

  typedef struct {
    logic [7:0] vec;
    int         beats_hz;
    int         beats_lz;
    int         first_hz;
    int         first_lz;
  } vec_t;

  beat_t q_hz[$];
  beat_t q_lz[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare any beat that transfers this cycle against the scoreboard.
  task automatic mon();
    beat_t e;
    if (hz_valid && out_ready) begin
      if (q_hz.size() == 0) begin
        chk("hz_unexpected_beat", 1, 0);
      end else begin
        e = q_hz.pop_front();
        chk("hz_code", hz_code, e.code);
        chk("hz_last", hz_last, e.last);
        chk("hz_zero", hz_zero, e.zero);
      end
    end
    if (lz_valid && out_ready) begin
      if (q_lz.size() == 0) begin
        chk("lz_unexpected_beat", 1, 0);
      end else begin
        e = q_lz.pop_front();
        chk("lz_code", lz_code, e.code);
        chk("lz_last", lz_last, e.last);
        chk("lz_zero", lz_zero, e.zero);
      end
    end
  endtask

  // Sample on the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] v);
    int cnt;
    cnt = $countones(v);
    if (v == 8'd0) begin
      q_hz.push_back('{code: 3'd0, last: 1'b1, zero: 1'b1});
    end else begin
      for (int i = 7; i >= 0; i--)
        if (v[i]) begin
          cnt--;
          q_hz.push_back('{code: 3'(i), last: (cnt == 0), zero: 1'b0});
        end
      cnt = $countones(v);
      for (int i = 0; i < 8; i++)
        if (v[i]) begin
          cnt--;
          q_lz.push_back('{code: 3'(i), last: (cnt == 0), zero: 1'b0});
        end
    end
  endtask

  // Wait (bounded) for both instances to be ready, then present v for one cycle.
  task automatic send(input logic [7:0] v);
    int n = 0;
    while (!(hz_ready && lz_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("send_ready_timeout", 0, 1);
    in_vec   = v;
    in_valid = 1'b1;
    push_exp(v);
    tick();
    in_valid = 1'b0;
    in_vec   = 8'h00;
  endtask

  // Run until the scoreboard empties; returns number of cycles used.
  task automatic drain(output int n);
    n = 0;
    while ((q_hz.size() > 0 || q_lz.size() > 0) && n < 40) begin
      tick();
      n++;
    end
    if (n == 40) chk("drain_timeout", 0, 1);
  endtask

  vec_t tbl[6];
  int   n;

  initial begin
    tbl[0] = '{vec: 8'h01, beats_hz: 1, beats_lz: 1, first_hz: 0, first_lz: 0};
    tbl[1] = '{vec: 8'hA5, beats_hz: 4, beats_lz: 4, first_hz: 7, first_lz: 0};
    tbl[2] = '{vec: 8'h80, beats_hz: 1, beats_lz: 1, first_hz: 7, first_lz: 7};
    tbl[3] = '{vec: 8'h00, beats_hz: 1, beats_lz: 0, first_hz: 0, first_lz: 0};
    tbl[4] = '{vec: 8'h3C, beats_hz: 4, beats_lz: 4, first_hz: 5, first_lz: 2};
    tbl[5] = '{vec: 8'hFF, beats_hz: 8, beats_lz: 8, first_hz: 7, first_lz: 0};

    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",  hz_ready, 0);
    chk("rst_out_valid", hz_valid, 0);
    chk("rst_out_code",  hz_code,  0);
    chk("rst_out_last",  hz_last,  0);
    chk("rst_out_zero",  hz_zero,  0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", hz_ready, 1);

    // Table: full bursts with out_ready held high.
    foreach (tbl[k]) begin
      send(tbl[k].vec);
      chk("lat_hz_valid", hz_valid, 1);
      chk("lat_lz_valid", lz_valid, (tbl[k].beats_lz > 0) ? 1 : 0);
      chk("busy_hz_ready", hz_ready, 0);
      chk("lz_ready_zero_drop", lz_ready, (tbl[k].beats_lz == 0) ? 1 : 0);
      chk("first_hz_code", hz_code, tbl[k].first_hz);
      if (tbl[k].beats_lz > 0) chk("first_lz_code", lz_code, tbl[k].first_lz);
      n = 0;
      while (q_hz.size() > 0 && n < 40) begin
        chk("burst_in_ready_low", hz_ready, 0);
        tick();
        n++;
      end
      chk("beats_back_to_back", n, tbl[k].beats_hz);
      chk("lz_queue_empty", q_lz.size(), 0);
      chk("idle_hz_ready", hz_ready, 1);
      chk("idle_lz_ready", lz_ready, 1);
    end

    // Backpressure: code held for 3 stalled cycles, then 7,6 / 6,7.
    out_ready = 1'b0;
    send(8'hC0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hz_valid", hz_valid, 1);
      chk("bp_hz_code",  hz_code,  7);
      chk("bp_hz_last",  hz_last,  0);
      chk("bp_lz_code",  lz_code,  6);
    end
    out_ready = 1'b1;
    drain(n);
    chk("bp_beats", n, 2);

    // Enable drop mid-burst freezes, then resumes at the same code.
    send(8'hFF);
    tick();
    tick();
    en = 1'b0;
    #1;
    chk("en0_hz_valid", hz_valid, 0);
    chk("en0_lz_valid", lz_valid, 0);
    tick();
    tick();
    chk("en0_hold_valid", hz_valid, 0);
    en = 1'b1;
    #1;
    chk("resume_hz_code", hz_code, 5);
    chk("resume_lz_code", lz_code, 2);
    drain(n);
    chk("resume_beats", n, 6);
    en = 1'b0;
    #1;
    chk("en0_idle_ready", hz_ready, 0);
    en = 1'b1;
    #1;

    // Reset mid-burst: outputs drop immediately, no stale beats afterwards.
    send(8'hFF);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", hz_valid, 0);
    chk("mid_rst_ready", hz_ready, 0);
    chk("mid_rst_code",  hz_code,  0);
    chk("mid_rst_lz_valid", lz_valid, 0);
    tick();
    q_hz.delete();
    q_lz.delete();
    rst_n = 1'b1;
    #1;
    chk("after_rst_hz_ready", hz_ready, 1);
    chk("after_rst_lz_ready", lz_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale_hz", hz_valid, 0);
      chk("no_stale_lz", lz_valid, 0);
    end

    // Fresh vector after reset behaves normally.
    send(8'h12);
    chk("post_rst_first_hz", hz_code, 4);
    chk("post_rst_first_lz", lz_code, 1);
    drain(n);
    chk("post_rst_beats", n, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
